// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: widths, canonical NOP and fetch state encoding.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // ADDI x0,x0,0
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } fetch_state_e;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_gen.sv
// Next program-counter select (redirect / sequential / hold) with target alignment check.
module pc_next_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc_next_c,
    output logic            misaligned_c
);

    // A misaligned target leaves the PC untouched; the caller traps instead.
    always_comb begin
        misaligned_c = redirect && !is_aligned(redirect_pc);
        pc_next_c    = pc;
        if (redirect) begin
            if (!misaligned_c) begin
                pc_next_c = redirect_pc;
            end
        end else if (advance) begin
            pc_next_c = pc + XLEN'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instr_mem and presents
// {instruction, PC, valid} to the decoder, trapping on misaligned redirects.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] iaddr,
    output logic            cs_n,
    input  logic [XLEN-1:0] instr_code_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid_o,
    output logic            misaligned_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            misaligned_q, misaligned_d;

    logic            redirect_c;
    logic            fetch_c;
    logic [XLEN-1:0] pc_next_c;
    logic            target_misaligned_c;

    // Redirects are only honoured once the memory has finished its start-up cycle.
    assign redirect_c = redirect_i && (state_q != S_IDLE);
    assign fetch_c    = (state_q == S_RUN) && !redirect_i && !stall_i;

    pc_next_gen u_pc_next_gen (
        .pc           (pc_q),
        .advance      (fetch_c),
        .redirect     (redirect_c),
        .redirect_pc  (redirect_pc_i),
        .pc_next_c    (pc_next_c),
        .misaligned_c (target_misaligned_c)
    );

    assign pc_d = pc_next_c;

    always_comb begin
        state_d      = state_q;
        req_pc_d     = req_pc_q;
        pend_d       = pend_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        cs_n         = 1'b1;
        iaddr        = pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN, S_TRAP: begin
                if (redirect_c) begin
                    // Flush: the in-flight response belongs to the wrong path.
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    if (target_misaligned_c) begin
                        state_d      = S_TRAP;
                        misaligned_d = 1'b1;
                        instr_pc_d   = redirect_pc_i;
                    end else begin
                        state_d      = S_RUN;
                        misaligned_d = 1'b0;
                    end
                end else if (fetch_c) begin
                    cs_n     = 1'b0;
                    req_pc_d = pc_q;
                    pend_d   = 1'b1;
                    valid_d  = pend_q;
                    if (pend_q) begin
                        instr_d    = instr_code_i;
                        instr_pc_d = req_pc_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (rst) begin
            cs_n  = 1'b1;
            iaddr = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            pend_q       <= 1'b0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= RESET_PC;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            pend_q       <= pend_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign instr_o       = instr_q;
    assign pc_o          = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fetch-stream model queues expected
// instructions, an instr_mem model serves data, a negedge monitor checks.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int M_WARM = 0;
    localparam int M_RUN  = 1;
    localparam int M_TRAP = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] iaddr;
    logic        cs_n;
    logic [31:0] instr_code;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        misaligned;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .iaddr         (iaddr),
        .cs_n          (cs_n),
        .instr_code_i  (instr_code),
        .instr_o       (instr),
        .pc_o          (pc),
        .instr_valid_o (instr_valid),
        .misaligned_o  (misaligned)
    );

    always #5 clk = ~clk;

    // instr_mem model: word k holds 0x1000_0000 + k
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    logic [31:0] mem_addr = '0;
    always @(posedge clk) if (!cs_n) mem_addr <= iaddr;
    assign instr_code = mem_word(mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch-stream reference model
    exp_t        exp_q[$];
    int          mode = M_WARM;
    bit          known = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] next_pc = RST_PC;
    logic [31:0] trap_pc = '0;

    bit          chk_en = 1'b0;
    bit          chk_regs = 1'b0;
    logic        exp_cs_n = 1'b1;
    logic [31:0] exp_iaddr = '0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_trap_pc = '0;

    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; redirect = d; redirect_pc = t;
        exp_cs_n    = !(!r && mode == M_RUN && !d && !s);
        exp_iaddr   = r ? RST_PC : next_pc;
        exp_mis     = (mode == M_TRAP);
        exp_trap_pc = trap_pc;
        chk_regs    = known;
        chk_en      = 1'b1;
        if (r) begin
            if (pend) e = exp_q.pop_back();
            pend = 1'b0; mode = M_WARM; next_pc = RST_PC; known = 1'b1;
        end else if (mode == M_WARM) begin
            mode = M_RUN;
        end else if (d) begin
            if (pend) e = exp_q.pop_back();
            pend = 1'b0;
            if (t[1:0] != 2'b00) begin
                mode = M_TRAP; trap_pc = t;
            end else begin
                mode = M_RUN; next_pc = t;
            end
        end else if (mode == M_RUN && !s) begin
            e.pc = next_pc; e.instr = mem_word(next_pc);
            exp_q.push_back(e);
            pend = 1'b1;
            next_pc = next_pc + 32'd4;
        end
    endtask

    // Monitor: memory interface every cycle; outputs against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            check("cs_n", 32'(cs_n), 32'(exp_cs_n));
            check("iaddr", iaddr, exp_iaddr);
            if (chk_regs) begin
                check("misaligned", 32'(misaligned), 32'(exp_mis));
                if (exp_mis) begin
                    check("trap_valid", 32'(instr_valid), 32'd0);
                    check("trap_pc", pc, exp_trap_pc);
                end
                if (instr_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL spurious_valid: pc_o 0x%08h with nothing expected at %0t", pc, $time);
                    end else begin
                        check("out_pc", pc, exp_q[0].pc);
                        check("out_instr", instr, exp_q[0].instr);
                        if (rst || redirect || !stall) e = exp_q.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] tgt;
        bit          seen;
        logic        r, s, d;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0);

        // Boot: first valid in cycle 3, then one word per cycle
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            check("boot_valid", 32'(instr_valid), (c >= 3) ? 32'd1 : 32'd0);
            if (c == 0) begin
                check("boot_pc", pc, RST_PC);
                check("boot_instr", instr, NOP);
                check("boot_mis", 32'(misaligned), 32'd0);
            end
            if (c >= 3) check("boot_seq_pc", pc, 32'((c - 3) * 4));
        end

        // Stall for 3 cycles with a request outstanding
        cycle(1'b0, 1'b1, 1'b0, '0);
        held = pc;
        cycle(1'b0, 1'b1, 1'b0, '0); check("stall_hold", pc, held);
        cycle(1'b0, 1'b1, 1'b0, '0); check("stall_hold", pc, held);
        cycle(1'b0, 1'b0, 1'b0, '0); check("stall_release", pc, held);
        check("stall_valid", 32'(instr_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, '0); check("stall_next", pc, held + 32'd4);

        // Redirect to 0x100
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        cycle(1'b0, 1'b0, 1'b0, '0); check("redir_gap1", 32'(instr_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0); check("redir_gap2", 32'(instr_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0); check("redir_valid", 32'(instr_valid), 32'd1);
        check("redir_pc", pc, 32'h0000_0100);
        check("redir_instr", instr, 32'h1000_0040);

        // Redirect and stall together, stall held afterwards
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (instr_valid) begin
                seen = 1'b1;
                check("rs_first_pc", pc, 32'h0000_0300);
            end
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL rs_timeout: no valid output within 10 cycles of release");
        end

        // Misaligned redirect traps until an aligned redirect
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, logic'(i % 2), 1'b0, '0);
            check("trap_mis", 32'(misaligned), 32'd1);
            check("trap_nv", 32'(instr_valid), 32'd0);
            check("trap_pco", pc, 32'h0000_0102);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        cycle(1'b0, 1'b0, 1'b0, '0); check("recover_mis", 32'(misaligned), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0); check("recover_valid", 32'(instr_valid), 32'd1);
        check("recover_pc", pc, 32'h0000_0200);

        // PC wrap-around
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (i == 3) check("wrap_pc0", pc, 32'hFFFF_FFF8);
            if (i == 4) check("wrap_pc1", pc, 32'hFFFF_FFFC);
            if (i == 5) begin
                check("wrap_pc2", pc, 32'h0000_0000);
                check("wrap_instr", instr, 32'h1000_0000);
            end
        end

        // Reset mid-stream
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("mrst_pc", pc, RST_PC);
        check("mrst_instr", instr, NOP);
        check("mrst_valid", 32'(instr_valid), 32'd0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0, '0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 30);
            d = !r && (mode != M_WARM) && ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | ($urandom & 32'h0000_001C);
            else                           tgt = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            cycle(r, s, d, tgt);
        end

        // Drain: flush everything via a trap and confirm nothing is left owed
        repeat (2) cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0001);
        cycle(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of instr_mem. Owns the program counter and drives instr_mem's iaddr/cs_n.
- Captures the returned instrCode and presents {instruction, PC, valid} to the decoder.
- Handles sequential fetch, branch/jump redirect, back-pressure stall and misaligned-target trapping.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- NOP_INSTR, 32'h0000_0013, value held on instr_o while no valid instruction is present (ADDI x0,x0,0).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- stall_i  input  1  downstream cannot accept; freeze fetch.
- redirect_i  input  1  branch/jump taken this cycle.
- redirect_pc_i  input  32  target PC when redirect_i=1.
- iaddr  output  32  byte address to instr_mem.
- cs_n  output  1  active-low chip select to instr_mem; 0 = memory latches iaddr at next edge.
- instr_code_i  input  32  instr_mem data; valid the cycle after a cs_n=0 edge, held while cs_n=1.
- instr_o  output  32  instruction to decoder.
- pc_o  output  32  PC of instr_o.
- instr_valid_o  output  1  instr_o/pc_o are a real instruction.
- misaligned_o  output  1  redirect target had bits[1:0]!=0; fetch halted.

Behaviour:
- State register with three states: S_IDLE, S_RUN, S_TRAP.
- Internal registers:
  - pc_q: next address to request.
  - req_pc_q: address of the in-flight request.
  - pend_q: a response is outstanding.
  - instr_q, instr_pc_q, valid_q.
- Reset (rst=1 at edge) has priority over everything:
  - pc_q=RESET_PC, req_pc_q=RESET_PC, pend_q=0, valid_q=0.
  - instr_q=NOP_INSTR, instr_pc_q=RESET_PC, misaligned_o=0, state=S_IDLE.
  - Outputs during and right after reset: cs_n=1, iaddr=RESET_PC, instr_valid_o=0.
- S_IDLE: cs_n=1 for exactly one cycle so instr_mem finishes its initial load, then go to S_RUN.
- S_RUN, no stall, no redirect:
  - cs_n=0, iaddr=pc_q.
  - At the edge: pc_q<=pc_q+4 (mod 2^32; 0xFFFF_FFFC wraps to 0), req_pc_q<=pc_q, pend_q<=1.
  - If pend_q was 1: instr_q<=instr_code_i, instr_pc_q<=req_pc_q, valid_q<=1. Otherwise valid_q<=0.
- Latency and throughput:
  - Request issued in cycle N (cs_n=0), data present in cycle N+1, shown on instr_o with instr_valid_o=1 in cycle N+2.
  - Steady-state throughput is one instruction per cycle.
- stall_i=1 (no redirect):
  - cs_n=1 and every register holds; iaddr stays at pc_q.
  - instr_mem does not relatch, so any outstanding response stays readable on instr_code_i and is captured on the first unstalled edge. No instruction is lost or duplicated.
- redirect_i=1 (takes priority over stall_i):
  - cs_n=1 that cycle.
  - At the edge: pend_q<=0 (in-flight response discarded), valid_q<=0, instr_q<=NOP_INSTR.
  - If redirect_pc_i[1:0]==0: pc_q<=redirect_pc_i, state stays S_RUN. The first target instruction is valid 3 cycles after the redirect cycle.
  - Otherwise: state<=S_TRAP, misaligned_o<=1, pc_o latched to redirect_pc_i.
- S_TRAP:
  - cs_n=1, instr_valid_o=0, misaligned_o=1; stall_i is ignored.
  - Leave only by reset or by an aligned redirect, which clears misaligned_o and returns to S_RUN.
- Output mapping: instr_o=instr_q, pc_o=instr_pc_q, instr_valid_o=valid_q. All outputs are registered except iaddr/cs_n, which are combinational from state, pc_q, stall_i and redirect_i.
- Simultaneous redirect and stall: redirect applies, stall is ignored. On the following cycle a still-asserted stall holds the new pc_q.
- Reset mid-operation: any pending request is abandoned and no stale instr_code_i is ever captured, because pend_q is cleared.

Decomposition:
- Shared package riscv_pkg: XLEN=32, INSTR_BYTES=4, NOP_INSTR constant, and fetch state encoding (S_IDLE, S_RUN, S_TRAP).
- Optional sub-module pc_next_gen: combinational next-PC select (pc+4 / redirect / hold) plus alignment check.
- Everything else lives in fetch_unit.

Test Plan:
- Reset release, memory preloaded with word k = 0x1000_0000+k, no stall:
  - cs_n=0 from cycle 1 with iaddr 0,4,8,...
  - instr_valid_o rises in cycle 3 with pc_o=0, instr_o=0x1000_0000, then one word per cycle.
- stall_i high for 3 cycles while a request is pending:
  - cs_n=1, iaddr frozen, outputs held.
  - After release the next instruction is exactly pc+4, with no gaps or duplicates.
- redirect_i with redirect_pc_i=0x0000_0100 mid-stream:
  - The in-flight word is dropped and instr_valid_o=0 for 2 cycles.
  - The next valid output has pc_o=0x100.
- Redirect and stall asserted in the same cycle: redirect wins and pc_q=target. Stall then holds until released.
- redirect_pc_i=0x0000_0102:
  - misaligned_o=1, cs_n=1 and instr_valid_o=0 persist.
  - A subsequent redirect to 0x200 recovers to normal fetch.
- PC at 0xFFFF_FFFC: the next iaddr is 0x0000_0000. rst asserted mid-stream gives pc_o=RESET_PC, instr_o=NOP_INSTR and valid=0 on the next cycle.
